// File: rtl/poly_mac_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poly_mac_acc_pkg
// Description : Shared constants and FSM state encoding for the cyclic
//               polynomial multiply-accumulate block (ring Z[x]/(x^N - 1)).
//               Contents: default N / CW / AW, state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package poly_mac_acc_pkg;

    localparam int c_N  = 4;    // number of coefficients
    localparam int c_CW = 2;    // coefficient width
    localparam int c_AW = 6;    // accumulator width, >= 2*CW + clog2(N)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pm_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : pm_mac_lane
// Description : One coefficient lane: CW x CW unsigned multiply, zero-extend
//               to AW and either load (first sample) or add into the lane
//               accumulator.
// Ports       : clk, reset (async, active-low), load, acc_en, a, b -> acc
// Revision    : 1.0 - initial release
// ============================================================================
module pm_mac_lane #(
    parameter int CW = 2,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,     // k=0 sample: overwrite accumulator
    input  logic          acc_en,   // k>0 sample: add into accumulator
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    output logic [AW-1:0] acc
);

    logic [2*CW-1:0] w_prod;
    logic [AW-1:0]   w_prod_ext;
    logic [AW-1:0]   r_acc;

    assign w_prod     = {{CW{1'b0}}, a} * {{CW{1'b0}}, b};
    assign w_prod_ext = {{(AW-2*CW){1'b0}}, w_prod};

    // Load discards any residue of the previous operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= w_prod_ext;
        end else if (acc_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/poly_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : poly_mac_acc
// Description : Cyclic convolution c_i = sum_k a[(i-k) mod N] * b[k] over N
//               cycles. Upstream presents one rotation of operand A (coef0..3)
//               and one coefficient of B (b_coef) per accepted cycle.
// Ports       : clk, reset (async, active-low), start, coef0..coef3, b_coef
//               -> res0..res3 (held result), valid (1-cycle), busy (ACC)
// Revision    : 1.0 - initial release
// ============================================================================
module poly_mac_acc
    import poly_mac_acc_pkg::*;
#(
    parameter int N  = c_N,     // port list below is written for N = 4
    parameter int CW = c_CW,
    parameter int AW = c_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] coef0,
    input  logic [CW-1:0] coef1,
    input  logic [CW-1:0] coef2,
    input  logic [CW-1:0] coef3,
    input  logic [CW-1:0] b_coef,
    output logic [AW-1:0] res0,
    output logic [AW-1:0] res1,
    output logic [AW-1:0] res2,
    output logic [AW-1:0] res3,
    output logic          valid,
    output logic          busy
);

    localparam int                 c_CNT_W = $clog2(N) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_load;
    logic               w_acc_en;
    logic [CW-1:0]      w_coef [N];
    logic [AW-1:0]      w_acc  [N];

    assign w_coef[0] = coef0;
    assign w_coef[1] = coef1;
    assign w_coef[2] = coef2;
    assign w_coef[3] = coef3;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    // DONE behaves like IDLE for start, giving back-to-back operation.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_ACC;
            ST_ACC:  if (r_cnt == c_LAST) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_ACC : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        busy     = (r_state == ST_ACC);
        valid    = (r_state == ST_DONE);
        w_load   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_acc_en = (r_state == ST_ACC);
    end

    // Step counter: holds the index of the next rotation to accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= c_CNT_W'(1);
        end else if (w_acc_en) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // ---------------- per-lane datapaths ----------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            pm_mac_lane #(
                .CW (CW),
                .AW (AW)
            ) u_lane (
                .clk    (clk),
                .reset  (reset),
                .load   (w_load),
                .acc_en (w_acc_en),
                .a      (w_coef[gi]),
                .b      (b_coef),
                .acc    (w_acc[gi])
            );
        end
    endgenerate

    assign res0 = w_acc[0];
    assign res1 = w_acc[1];
    assign res2 = w_acc[2];
    assign res3 = w_acc[3];

endmodule
`default_nettype wire

// File: tb/tb_poly_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_mac_acc
// Description : Self-checking bench for poly_mac_acc. Stimulus pushes the
//               expected cyclic-convolution result into a queue; a monitor
//               pops and compares on every valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_mac_acc;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] coef0, coef1, coef2, coef3, b_coef;
    logic [AW-1:0] res0, res1, res2, res3;
    logic          valid, busy;

    int checks = 0;
    int errors = 0;
    int busy_run = 0;

    logic [4*AW-1:0] exp_q [$];
    logic [4*AW-1:0] last_exp = '0;
    logic [4*AW-1:0] got;

    always #5 clk = ~clk;

    poly_mac_acc #(.N(N), .CW(CW), .AW(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .coef0  (coef0),
        .coef1  (coef1),
        .coef2  (coef2),
        .coef3  (coef3),
        .b_coef (b_coef),
        .res0   (res0),
        .res1   (res1),
        .res2   (res2),
        .res3   (res3),
        .valid  (valid),
        .busy   (busy)
    );

    assign got = {res3, res2, res1, res0};

    // Reference: plain cyclic convolution in Z[x]/(x^N - 1).
    function automatic logic [4*AW-1:0] model(input logic [4*CW-1:0] a,
                                              input logic [4*CW-1:0] b);
        logic [4*AW-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int k = 0; k < N; k++)
                s += int'(a[((i - k + N) % N)*CW +: CW]) * int'(b[k*CW +: CW]);
            r[i*AW +: AW] = AW'(s);
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] rot(input logic [4*CW-1:0] a,
                                          input int i, input int k);
        return a[((i - k + N) % N)*CW +: CW];
    endfunction

    // Present rotations k=0..N-1; start is high at k=0 and while k < hold.
    task automatic drive_op(input logic [4*CW-1:0] a, input logic [4*CW-1:0] b,
                            input int hold);
        logic [4*AW-1:0] e;
        e = model(a, b);
        exp_q.push_back(e);
        last_exp = e;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            start  = (k == 0) || (k < hold);
            coef0  = rot(a, 0, k);
            coef1  = rot(a, 1, k);
            coef2  = rot(a, 2, k);
            coef3  = rot(a, 3, k);
            b_coef = b[k*CW +: CW];
        end
    endtask

    // Idle with junk on the data inputs; afterwards the result must be held.
    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            start  = 1'b0;
            coef0  = CW'($urandom);
            coef1  = CW'($urandom);
            coef2  = CW'($urandom);
            coef3  = CW'($urandom);
            b_coef = CW'($urandom);
        end
        if (n > 0) begin
            checks++;
            if (got !== last_exp) begin
                errors++;
                $display("FAIL hold: res=%h expected %h", got, last_exp);
            end
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (got !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: res=%h valid=%b busy=%b expected all 0",
                     name, got, valid, busy);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            busy_run = 0;
        end else begin
            if (valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: res=%h expected no valid", got);
                end else begin
                    if (got !== exp_q[0]) begin
                        errors++;
                        $display("FAIL result: res=%h expected %h", got, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (busy) begin
                    errors++;
                    $display("FAIL valid_busy: busy=%b expected 0 with valid", busy);
                end
            end
            // ACC occupies the cycles after the k=0..N-2 edges: N-1 cycles.
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                checks++;
                if (busy_run != N - 1) begin
                    errors++;
                    $display("FAIL busy_len: got %0d cycles expected %0d",
                             busy_run, N - 1);
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        logic [4*CW-1:0] ra, rb;
        int wait_cnt;
        reset  = 1'b0;
        start  = 1'b0;
        coef0  = '0; coef1 = '0; coef2 = '0; coef3 = '0; b_coef = '0;
        #1;
        check_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // identity: a=[1,2,3,0], b=[1,0,0,0]
        drive_op({2'd0, 2'd3, 2'd2, 2'd1}, {2'd0, 2'd0, 2'd0, 2'd1}, 1);
        idle(2);
        // multiply by x: cyclic wrap of a3
        drive_op({2'd0, 2'd3, 2'd2, 2'd1}, {2'd0, 2'd0, 2'd1, 2'd0}, 1);
        idle(2);
        // all-max operands, largest result
        drive_op({4{2'd3}}, {4{2'd3}}, 1);
        idle(1);
        // start held 6 cycles: one op, then a back-to-back op from DONE
        drive_op({2'd1, 2'd0, 2'd2, 2'd3}, {2'd2, 2'd1, 2'd0, 2'd3}, 4);
        drive_op({2'd3, 2'd1, 2'd1, 2'd2}, {2'd0, 2'd3, 2'd1, 2'd1}, 2);
        idle(2);
        // two consecutive ops with different operands: no residue
        drive_op({4{2'd3}}, {4{2'd3}}, 1);
        idle(1);
        drive_op({2'd0, 2'd0, 2'd0, 2'd1}, {2'd0, 2'd0, 2'd0, 2'd1}, 1);
        idle(2);

        // asynchronous reset while presenting k=2
        ra = {2'd2, 2'd3, 2'd1, 2'd2};
        rb = {2'd1, 2'd1, 2'd3, 2'd2};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start  = (k == 0);
            coef0  = rot(ra, 0, k);
            coef1  = rot(ra, 1, k);
            coef2  = rot(ra, 2, k);
            coef3  = rot(ra, 3, k);
            b_coef = rb[k*CW +: CW];
        end
        #2 reset = 1'b0;
        #1 check_zero("async_abort");
        last_exp = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive_op({2'd1, 2'd2, 2'd3, 2'd3}, {2'd3, 2'd0, 2'd2, 2'd1}, 1);
        idle(2);

        // randomized operations with random gaps and start holding
        for (int t = 0; t < 24; t++) begin
            drive_op((4*CW)'($urandom), (4*CW)'($urandom), $urandom_range(1, 6));
            idle($urandom_range(0, 2));
        end
        idle(1);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
